// File: rtl/cplx_accum.sv
// rtl/cplx_accum.sv - frame accumulator for a complex product stream
//
// Sums len_i+1 signed complex samples into ACC_WIDTH-bit accumulators and
// presents one result per frame on a valid/ready output. Build option:
//   CPLX_ACC_SAT_EN  defined   -> overflowing component clamps to max/min
//                    undefined -> overflowing component wraps modulo 2^ACC_WIDTH
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   flush_i      synchronous abort of the current frame or pending result
//   len_i        frame length minus one, captured on the first beat
//   in_valid_i / in_ready_o / in_re_i / in_im_i    input product stream
//   out_valid_o / out_ready_i / out_re_o / out_im_o / out_ovf_o   result
module cplx_accum #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 24,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic [LEN_WIDTH-1:0]  len_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] in_re_i,
   input  logic [DATA_WIDTH-1:0] in_im_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [ACC_WIDTH-1:0]  out_re_o,
   output logic [ACC_WIDTH-1:0]  out_im_o,
   output logic                  out_ovf_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   state_t               state_q, state_d;
   logic [ACC_WIDTH-1:0] acc_re_q, acc_re_d;
   logic [ACC_WIDTH-1:0] acc_im_q, acc_im_d;
   logic                 ovf_q, ovf_d;
   logic [LEN_WIDTH-1:0] cnt_q, cnt_d;

   logic [ACC_WIDTH-1:0] in_re_ext, in_im_ext;
   logic [ACC_WIDTH:0]   sum_re, sum_im;

   // Signed size cast sign-extends the input samples.
   assign in_re_ext = ACC_WIDTH'($signed(in_re_i));
   assign in_im_ext = ACC_WIDTH'($signed(in_im_i));

   // Returns {overflow, result}. Overflow is equal operand signs with a
   // differing sum sign; the clamp direction follows the operands' sign.
   function automatic logic [ACC_WIDTH:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                  input logic [ACC_WIDTH-1:0] b);
      logic [ACC_WIDTH-1:0] s;
      logic                 ov;
      s  = a + b;
      ov = (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
`ifdef CPLX_ACC_SAT_EN
      if (ov) begin
         s = a[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
      end
`endif
      return {ov, s};
   endfunction

   assign sum_re = acc_add(acc_re_q, in_re_ext);
   assign sum_im = acc_add(acc_im_q, in_im_ext);

   always_comb begin
      state_d  = state_q;
      acc_re_d = acc_re_q;
      acc_im_d = acc_im_q;
      ovf_d    = ovf_q;
      cnt_d    = cnt_q;

      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               acc_re_d = in_re_ext;
               acc_im_d = in_im_ext;
               ovf_d    = 1'b0;
               cnt_d    = len_i;
               state_d  = (len_i == '0) ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            if (in_valid_i) begin
               acc_re_d = sum_re[ACC_WIDTH-1:0];
               acc_im_d = sum_im[ACC_WIDTH-1:0];
               ovf_d    = ovf_q | sum_re[ACC_WIDTH] | sum_im[ACC_WIDTH];
               cnt_d    = cnt_q - LEN_WIDTH'(1);
               // cnt_q counts beats still owed after this one plus one.
               if (cnt_q == LEN_WIDTH'(1)) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (out_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Flush overrides any beat or handshake in the same cycle.
      if (flush_i) begin
         state_d  = IDLE;
         acc_re_d = '0;
         acc_im_d = '0;
         ovf_d    = 1'b0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         acc_re_q <= '0;
         acc_im_q <= '0;
         ovf_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         acc_re_q <= acc_re_d;
         acc_im_q <= acc_im_d;
         ovf_q    <= ovf_d;
         cnt_q    <= cnt_d;
      end
   end

   // Handshake flags decode registered state only: no out_ready_i -> in_ready_o path.
   assign in_ready_o  = (state_q != HOLD);
   assign out_valid_o = (state_q == HOLD);
   assign out_re_o    = acc_re_q;
   assign out_im_o    = acc_im_q;
   assign out_ovf_o   = ovf_q;

endmodule

// File: tb/tb_cplx_accum.sv
// tb/tb_cplx_accum.sv - self-checking bench for cplx_accum
module tb_cplx_accum;

   localparam int DW = 16;
   localparam int AW = 20;
   localparam int LW = 8;
   localparam longint AMAX = (64'sd1 <<< (AW-1)) - 1;
   localparam longint AMIN = -(64'sd1 <<< (AW-1));
   localparam longint AMASK = (64'sd1 <<< AW) - 1;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          flush_i = 1'b0;
   logic [LW-1:0] len_i = '0;
   logic          in_valid_i = 1'b0;
   logic          in_ready_o;
   logic [DW-1:0] in_re_i = '0;
   logic [DW-1:0] in_im_i = '0;
   logic          out_valid_o;
   logic          out_ready_i = 1'b1;
   logic [AW-1:0] out_re_o;
   logic [AW-1:0] out_im_o;
   logic          out_ovf_o;

   int n_checks = 0;
   int n_errors = 0;
   bit started = 1'b0;

   cplx_accum #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .len_i       (len_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_re_i     (in_re_i),
      .in_im_i     (in_im_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_re_o    (out_re_o),
      .out_im_o    (out_im_o),
      .out_ovf_o   (out_ovf_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: mathematical sums with range folding per beat.
   longint m_re = 0, m_im = 0;
   bit     m_ovf = 1'b0, m_hold = 1'b0;
   int     m_rem = 0;

   function automatic longint fold(input longint v, inout bit ov);
      longint r;
      r = v;
      if (v > AMAX || v < AMIN) begin
         ov = 1'b1;
`ifdef CPLX_ACC_SAT_EN
         r = (v > AMAX) ? AMAX : AMIN;
`else
         r = v & AMASK;
         if (r > AMAX) r = r - (64'sd1 <<< AW);
`endif
      end
      return r;
   endfunction

   always @(posedge clk) begin
      longint sre, sim;
      sre = longint'($signed(in_re_i));
      sim = longint'($signed(in_im_i));
      if (rst_i || flush_i) begin
         m_hold = 1'b0; m_rem = 0; m_re = 0; m_im = 0; m_ovf = 1'b0;
      end else if (m_hold) begin
         if (out_ready_i) m_hold = 1'b0;
      end else if (in_valid_i) begin
         if (m_rem == 0) begin
            m_re = sre; m_im = sim; m_ovf = 1'b0; m_rem = int'(len_i) + 1;
         end else begin
            m_re = fold(m_re + sre, m_ovf);
            m_im = fold(m_im + sim, m_ovf);
         end
         m_rem--;
         if (m_rem == 0) m_hold = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("in_ready", longint'(in_ready_o), longint'(!m_hold));
         check("out_valid", longint'(out_valid_o), longint'(m_hold));
         if (m_hold) begin
            check("out_re", longint'($signed(out_re_o)), m_re);
            check("out_im", longint'($signed(out_im_o)), m_im);
            check("out_ovf", longint'(out_ovf_o), longint'(m_ovf));
         end
      end
   end

   task automatic beat(input int re, input int im, input int len);
      in_valid_i = 1'b1;
      in_re_i    = DW'(re);
      in_im_i    = DW'(im);
      len_i      = LW'(len);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_valid_i = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic lit(input string name, input longint exp_re, input longint exp_im,
                      input longint exp_ovf);
      check({name, "_valid"}, longint'(out_valid_o), 1);
      check({name, "_re"}, longint'($signed(out_re_o)), exp_re);
      check({name, "_im"}, longint'($signed(out_im_o)), exp_im);
      check({name, "_ovf"}, longint'(out_ovf_o), exp_ovf);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_in_ready", longint'(in_ready_o), 1);
      check("rst_out_valid", longint'(out_valid_o), 0);
      check("rst_out_re", longint'(out_re_o), 0);
      check("rst_out_im", longint'(out_im_o), 0);
      check("rst_out_ovf", longint'(out_ovf_o), 0);
      rst_i = 1'b0;
      started = 1'b1;
      idle(1);

      // Frame of 4, back-to-back.
      out_ready_i = 1'b1;
      for (int i = 1; i <= 4; i++) beat(i, -i, 3);
      in_valid_i = 1'b0;
      lit("frame4", 10, -10, 0);
      check("model_frame4_re", m_re, 10);
      idle(1);
      check("frame4_one_cycle", longint'(out_valid_o), 0);

      // Single-sample frame, then backpressure with ignored input beats.
      out_ready_i = 1'b0;
      beat(-32768, 32767, 0);
      in_valid_i = 1'b0;
      lit("single", -32768, 32767, 0);
      check("single_re_bits", longint'(out_re_o), 64'h0F8000);
      check("single_in_ready", longint'(in_ready_o), 0);
      for (int i = 0; i < 5; i++) begin
         beat(999, -999, 0);
         check("bp_re_stable", longint'($signed(out_re_o)), -32768);
         check("bp_in_ready", longint'(in_ready_o), 0);
      end
      in_valid_i = 1'b0;
      out_ready_i = 1'b1;
      @(negedge clk);
      check("bp_release_valid", longint'(out_valid_o), 0);
      check("bp_release_ready", longint'(in_ready_o), 1);
      beat(7, 8, 0);
      in_valid_i = 1'b0;
      lit("after_bp", 7, 8, 0);
      idle(1);

      // Largest in-range frame for a 20-bit accumulator: no overflow.
      for (int i = 0; i < 16; i++) beat(32767, -32768, 15);
      in_valid_i = 1'b0;
      lit("edge16", 524272, -524288, 0);
      idle(1);

      // 256-beat frame overflows both components.
      for (int i = 0; i < 256; i++) beat(32767, -32768, 255);
      in_valid_i = 1'b0;
`ifdef CPLX_ACC_SAT_EN
      lit("ovf256", 524287, -524288, 1);
`else
      lit("ovf256", -256, 0, 1);
`endif
      idle(1);

      // len_i changes mid-frame are ignored.
      beat(1, 1, 2);
      beat(2, 2, 0);
      check("midlen_no_early", longint'(out_valid_o), 0);
      beat(3, 3, 0);
      in_valid_i = 1'b0;
      lit("midlen", 6, 6, 0);
      idle(1);

      // Flush mid-frame with a coincident beat.
      for (int i = 0; i < 3; i++) beat(1, 1, 7);
      flush_i = 1'b1;
      beat(50, 50, 7);
      flush_i = 1'b0;
      idle(3);
      check("flush_no_valid", longint'(out_valid_o), 0);
      beat(5, 5, 1);
      beat(6, 6, 1);
      in_valid_i = 1'b0;
      lit("post_flush", 11, 11, 0);
      idle(1);

      // Flush while holding a result, coincident with the handshake.
      out_ready_i = 1'b0;
      beat(9, 9, 0);
      in_valid_i = 1'b0;
      flush_i = 1'b1;
      out_ready_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      check("flush_hold_valid", longint'(out_valid_o), 0);
      check("flush_hold_re", longint'(out_re_o), 0);

      // Reset while holding a result.
      out_ready_i = 1'b0;
      beat(100, -100, 0);
      in_valid_i = 1'b0;
      lit("pre_rst", 100, -100, 0);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      check("rst_hold_valid", longint'(out_valid_o), 0);
      check("rst_hold_re", longint'(out_re_o), 0);
      check("rst_hold_im", longint'(out_im_o), 0);
      check("rst_hold_ready", longint'(in_ready_o), 1);
      out_ready_i = 1'b1;
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
